// File: rtl/elevator_scheduler_if.sv
// Call-button, car-position and command signals shared by the scheduler
// and the car controller that drives it.
interface elevator_scheduler_if #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    car_floor;
    logic                  car_arrived;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  move_up;
    logic                  move_down;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;

    modport master (
        output call_req, car_floor, car_arrived,
        input  target_floor, move_up, move_down, door_open, dir_up, pending, busy
    );

    modport slave (
        input  call_req, car_floor, car_arrived,
        output target_floor, move_up, move_down, door_open, dir_up, pending, busy
    );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler for a single elevator car: latches calls, sequences
// moves floor to floor and times the door dwell at each served floor.
module elevator_scheduler #(
    parameter int NUM_FLOORS  = 4,
    parameter int FLOOR_W     = 2,
    parameter int DOOR_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_scheduler_if.slave  bus
);
    localparam int TIMER_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    // A same-floor call counts its own cycle as the first of a fresh dwell.
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'((DOOR_CYCLES > 1) ? DOOR_CYCLES - 2 : 0);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  move_up_q, move_up_d;
    logic                  move_down_q, move_down_d;
    logic                  door_open_q, door_open_d;
    logic                  dir_up_q, dir_up_d;
    logic                  busy_q, busy_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;

    logic [NUM_FLOORS-1:0] above_mask, below_mask;
    logic                  any_above, any_below;
    logic                  ahead, behind;
    logic                  here_pending, here_call;
    logic [FLOOR_W-1:0]    near_up, near_down;
    logic                  start_move, enter_door, go_up;

    function automatic logic [FLOOR_W-1:0] nearest_above(
        input logic [NUM_FLOORS-1:0] pend,
        input logic [FLOOR_W-1:0]    from
    );
        logic [FLOOR_W-1:0] res;
        res = from;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pend[i] && (i > int'(from))) res = FLOOR_W'(i);
        end
        return res;
    endfunction

    function automatic logic [FLOOR_W-1:0] nearest_below(
        input logic [NUM_FLOORS-1:0] pend,
        input logic [FLOOR_W-1:0]    from
    );
        logic [FLOOR_W-1:0] res;
        res = from;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i < int'(from))) res = FLOOR_W'(i);
        end
        return res;
    endfunction

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i] = (i > int'(bus.car_floor));
            below_mask[i] = (i < int'(bus.car_floor));
        end
    end

    assign any_above    = |(pending_q & above_mask);
    assign any_below    = |(pending_q & below_mask);
    assign ahead        = dir_up_q ? any_above : any_below;
    assign behind       = dir_up_q ? any_below : any_above;
    assign here_pending = pending_q[bus.car_floor];
    assign here_call    = bus.call_req[bus.car_floor];
    assign near_up      = nearest_above(pending_q, bus.car_floor);
    assign near_down    = nearest_below(pending_q, bus.car_floor);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | bus.call_req;
        target_d    = target_q;
        move_up_d   = 1'b0;
        move_down_d = 1'b0;
        door_open_d = 1'b0;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;
        start_move  = 1'b0;
        enter_door  = 1'b0;
        go_up       = dir_up_q;

        case (state_q)
            IDLE: begin
                if (here_pending || here_call) begin
                    enter_door = 1'b1;
                end else if (ahead) begin
                    start_move = 1'b1;
                end else if (behind) begin
                    start_move = 1'b1;
                    go_up      = ~dir_up_q;
                end
            end

            MOVE: begin
                // Between arrivals the target tracks the nearest call ahead,
                // so a closer new call retargets the car.
                if (bus.car_arrived && here_pending) begin
                    enter_door = 1'b1;
                end else if (ahead) begin
                    start_move = 1'b1;
                end else if (behind) begin
                    start_move = 1'b1;
                    go_up      = ~dir_up_q;
                end else begin
                    state_d = IDLE;
                end
            end

            DOOR: begin
                pending_d[bus.car_floor] = 1'b0;
                if (here_call) begin
                    door_open_d = 1'b1;
                    timer_d     = TIMER_RELOAD;
                end else if (timer_q != '0) begin
                    door_open_d = 1'b1;
                    timer_d     = timer_q - 1'b1;
                end else if (ahead) begin
                    start_move = 1'b1;
                end else if (behind) begin
                    start_move = 1'b1;
                    go_up      = ~dir_up_q;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_door) begin
            state_d                  = DOOR;
            door_open_d              = 1'b1;
            timer_d                  = TIMER_LOAD;
            pending_d[bus.car_floor] = 1'b0;
        end

        if (start_move) begin
            state_d     = MOVE;
            dir_up_d    = go_up;
            target_d    = go_up ? near_up : near_down;
            move_up_d   = go_up && (bus.car_floor != TOP_FLOOR);
            move_down_d = !go_up && (bus.car_floor != BOTTOM_FLOOR);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            target_q    <= '0;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
            door_open_q <= 1'b0;
            dir_up_q    <= 1'b1;
            busy_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
            door_open_q <= door_open_d;
            dir_up_q    <= dir_up_d;
            busy_q      <= busy_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.target_floor = target_q;
    assign bus.move_up      = move_up_q;
    assign bus.move_down    = move_down_q;
    assign bus.door_open    = door_open_q;
    assign bus.dir_up       = dir_up_q;
    assign bus.pending      = pending_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Cycle-table bench for elevator_scheduler: each record drives one cycle and
// states the registered outputs expected after that edge.
module tb_elevator_scheduler;
    localparam int NUM_FLOORS  = 4;
    localparam int FLOOR_W     = 2;
    localparam int DOOR_CYCLES = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    elevator_scheduler_if #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) bus ();

    elevator_scheduler #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W),
        .DOOR_CYCLES(DOOR_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // exp = {target[1:0], move_up, move_down, door_open, dir_up, pending[3:0], busy}
    typedef struct {
        logic        rst_n;
        logic [3:0]  call;
        logic [1:0]  floor;
        logic        arr;
        logic [10:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic void add(input logic rst_n, input logic [3:0] call,
                                input logic [1:0] floor, input logic arr,
                                input logic [1:0] tgt, input logic mu, input logic md,
                                input logic door, input logic dir,
                                input logic [3:0] pend, input logic busy);
        vec_t v;
        v.rst_n = rst_n;
        v.call  = call;
        v.floor = floor;
        v.arr   = arr;
        v.exp   = {tgt, mu, md, door, dir, pend, busy};
        vecs.push_back(v);
    endfunction

    function automatic logic [10:0] observed();
        return {bus.target_floor, bus.move_up, bus.move_down, bus.door_open,
                bus.dir_up, bus.pending, bus.busy};
    endfunction

    task automatic check_vec(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got tgt=%0d up=%b dn=%b door=%b dir=%b pend=%b busy=%b, expected tgt=%0d up=%b dn=%b door=%b dir=%b pend=%b busy=%b",
                     name, act[10:9], act[8], act[7], act[6], act[5], act[4:1], act[0],
                     exp[10:9], exp[8], exp[7], exp[6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] e;
        int door_cnt, lat;
        logic moved, pend_seen, done;

        reset           = 1'b0;
        bus.call_req    = '0;
        bus.car_floor   = '0;
        bus.car_arrived = 1'b0;

        // Reset, then idle with no calls.
        add(0, 4'b0000, 0, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        add(0, 4'b0000, 0, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        // Single up call to floor 2, passing floor 1.
        add(1, 4'b0100, 0, 0,  0, 0, 0, 0, 1, 4'b0100, 0);
        add(1, 4'b0000, 0, 0,  2, 1, 0, 0, 1, 4'b0100, 1);
        add(1, 4'b0000, 0, 0,  2, 1, 0, 0, 1, 4'b0100, 1);
        add(1, 4'b0000, 1, 1,  2, 1, 0, 0, 1, 4'b0100, 1);
        add(1, 4'b0000, 1, 0,  2, 1, 0, 0, 1, 4'b0100, 1);
        add(1, 4'b0000, 2, 1,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 0, 1, 4'b0000, 0);
        // Same-floor call while idle at floor 1.
        add(1, 4'b0010, 1, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 1, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 1, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 1, 0,  2, 0, 0, 0, 1, 4'b0000, 0);
        // Door extended by a same-floor call on the second door cycle.
        add(1, 4'b0100, 1, 0,  2, 0, 0, 0, 1, 4'b0100, 0);
        add(1, 4'b0000, 1, 0,  2, 1, 0, 0, 1, 4'b0100, 1);
        add(1, 4'b0000, 2, 1,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0100, 2, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 0, 1, 4'b0000, 0);
        // SCAN: moving up from 1 to 3, calls at 0 and 2 arrive; stops 2, 3, 0.
        add(1, 4'b1000, 1, 0,  2, 0, 0, 0, 1, 4'b1000, 0);
        add(1, 4'b0000, 1, 0,  3, 1, 0, 0, 1, 4'b1000, 1);
        add(1, 4'b0101, 1, 0,  3, 1, 0, 0, 1, 4'b1101, 1);
        add(1, 4'b0000, 1, 0,  2, 1, 0, 0, 1, 4'b1101, 1);
        add(1, 4'b0000, 2, 1,  2, 0, 0, 1, 1, 4'b1001, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 1, 1, 4'b1001, 1);
        add(1, 4'b0000, 2, 0,  2, 0, 0, 1, 1, 4'b1001, 1);
        add(1, 4'b0000, 2, 0,  3, 1, 0, 0, 1, 4'b1001, 1);
        add(1, 4'b0000, 3, 1,  3, 0, 0, 1, 1, 4'b0001, 1);
        add(1, 4'b0000, 3, 0,  3, 0, 0, 1, 1, 4'b0001, 1);
        add(1, 4'b0000, 3, 0,  3, 0, 0, 1, 1, 4'b0001, 1);
        add(1, 4'b0000, 3, 0,  0, 0, 1, 0, 0, 4'b0001, 1);
        add(1, 4'b0000, 2, 1,  0, 0, 1, 0, 0, 4'b0001, 1);
        add(1, 4'b0000, 1, 1,  0, 0, 1, 0, 0, 4'b0001, 1);
        add(1, 4'b0000, 0, 1,  0, 0, 0, 1, 0, 4'b0000, 1);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 1, 0, 4'b0000, 1);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 1, 0, 4'b0000, 1);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 0);
        // Idle at 0 heading down, call at 3: reverse to up, serve 3.
        add(1, 4'b1000, 0, 0,  0, 0, 0, 0, 0, 4'b1000, 0);
        add(1, 4'b0000, 0, 0,  3, 1, 0, 0, 1, 4'b1000, 1);
        add(1, 4'b0000, 3, 1,  3, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 3, 0,  3, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 3, 0,  3, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0000, 3, 0,  3, 0, 0, 0, 1, 4'b0000, 0);
        // Top floor, dir up, only floor 0 pending: reverse, never move up.
        add(1, 4'b0001, 3, 0,  3, 0, 0, 0, 1, 4'b0001, 0);
        add(1, 4'b0000, 3, 0,  0, 0, 1, 0, 0, 4'b0001, 1);
        add(1, 4'b0000, 2, 1,  0, 0, 1, 0, 0, 4'b0001, 1);
        add(1, 4'b0000, 1, 1,  0, 0, 1, 0, 0, 4'b0001, 1);
        add(1, 4'b0000, 0, 1,  0, 0, 0, 1, 0, 4'b0000, 1);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 1, 0, 4'b0000, 1);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 1, 0, 4'b0000, 1);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 0, 0, 4'b0000, 0);
        // Reset asserted mid-MOVE for two edges, calls ignored meanwhile.
        add(1, 4'b0100, 0, 0,  0, 0, 0, 0, 0, 4'b0100, 0);
        add(1, 4'b0000, 0, 0,  2, 1, 0, 0, 1, 4'b0100, 1);
        add(0, 4'b0000, 0, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        add(0, 4'b1000, 0, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        add(1, 4'b0000, 0, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        // car_arrived while idle is ignored.
        add(1, 4'b0000, 2, 1,  0, 0, 0, 0, 1, 4'b0000, 0);
        add(1, 4'b0000, 2, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        // Reset asserted mid-DOOR.
        add(1, 4'b0100, 2, 0,  0, 0, 0, 1, 1, 4'b0000, 1);
        add(0, 4'b0000, 2, 0,  0, 0, 0, 0, 1, 4'b0000, 0);
        add(1, 4'b0000, 2, 0,  0, 0, 0, 0, 1, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset           = vecs[i].rst_n;
            bus.call_req    = vecs[i].call;
            bus.car_floor   = vecs[i].floor;
            bus.car_arrived = vecs[i].arr;
            exp_q.push_back(vecs[i].exp);
            tick();
            e = exp_q.pop_front();
            check_vec($sformatf("vec%0d", i), observed(), e);
        end

        // Same-floor call: measure door length, no motion, bit never latched.
        bus.car_arrived = 1'b0;
        bus.car_floor   = 2'd1;
        bus.call_req    = 4'b0010;
        tick();
        bus.call_req = '0;
        door_cnt  = 0;
        moved     = 1'b0;
        pend_seen = 1'b0;
        done      = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.door_open) door_cnt++;
            if (bus.move_up || bus.move_down) moved = 1'b1;
            if (bus.pending[1]) pend_seen = 1'b1;
            if (door_cnt > 0 && !bus.busy) done = 1'b1;
            else tick();
        end
        check_int("samefloor_door_len", door_cnt, DOOR_CYCLES);
        check_int("samefloor_no_move", int'(moved), 0);
        check_int("samefloor_pend_hidden", int'(pend_seen), 0);
        check_int("samefloor_settled", int'(done), 1);

        // Latency from a call pulse to the move command.
        bus.call_req = 4'b1000;
        tick();
        bus.call_req = '0;
        lat = 1;
        for (int c = 0; c < 6 && !bus.move_up; c++) begin
            tick();
            lat++;
        end
        check_int("call_to_move_latency", lat, 2);
        check_int("call_to_move_target", int'(bus.target_floor), 3);
        check_int("call_to_move_no_down", int'(bus.move_down), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
